// File: rtl/window_pkg.sv
// Shared constants and types for the window packer.
//   DATA_W_DEF / K_DEF : default pixel width and window side
//   SLOT_W             : width of fill index and slot index (covers K*K-1 for K up to 7)
//   out_state_t        : output-register occupancy state
package window_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned K_DEF      = 3;
  localparam int unsigned SLOT_W     = 6;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/window_slot_map.sv
// Combinational fill-index to slot mapping.
//   idx       : fill index of the arriving pixel (0..K*K-1)
//   col_major : 0 = row-major (slot = idx), 1 = column-major (idx = c*K + r -> slot r*K + c)
//   slot      : destination slot in the packed window
module window_slot_map
  import window_pkg::*;
#(
  parameter int unsigned K = K_DEF
) (
  input  logic [SLOT_W-1:0] idx,
  input  logic              col_major,
  output logic [SLOT_W-1:0] slot
);

  int unsigned idx_i;
  int unsigned row;
  int unsigned col;

  always_comb begin
    idx_i = 32'(idx);
    row   = idx_i % K;
    col   = idx_i / K;
    slot  = col_major ? SLOT_W'(row * K + col) : idx;
  end

endmodule

// File: rtl/window_packer.sv
// Serial pixel stream to packed KxK window.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : pixel handshake, in_data carries the pixel
//   col_major             : arrival order, sampled on the first pixel of each window
//   flush                 : discard the partial window, drop any pixel this cycle
//   win_valid/win_ready   : window handshake, win_data carries K*K pixels (slot 0 at LSBs)
//   busy                  : partial window in progress
//   win_cnt               : windows emitted (wrapping)
module window_packer
  import window_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned K      = K_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  col_major,
  input  logic                  flush,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [K*K*DATA_W-1:0] win_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      win_cnt
);

  localparam int unsigned NPIX  = K * K;
  localparam int unsigned WIN_W = NPIX * DATA_W;
  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NPIX - 1);

  logic [SLOT_W-1:0] idx;
  logic [SLOT_W-1:0] slot;
  logic              mode_q;
  logic              mode_eff;
  logic              last;
  logic              accept;
  logic [WIN_W-1:0]  asm_q;
  logic [WIN_W-1:0]  filled;
  out_state_t        out_state;

  assign last      = (idx == LAST_IDX);
  // First pixel of a window uses the live mode; the rest use the latched one.
  assign mode_eff  = (idx == '0) ? col_major : mode_q;
  // Only the final pixel can stall, and only while the output register is still occupied.
  assign in_ready  = !flush && !(last && win_valid && !win_ready);
  assign accept    = in_valid && in_ready;
  assign win_valid = (out_state == OUT_FULL);
  assign busy      = (idx != '0);

  window_slot_map #(
    .K(K)
  ) u_slot_map (
    .idx      (idx),
    .col_major(mode_eff),
    .slot     (slot)
  );

  // Assembly register with the current pixel merged in; feeds both the
  // assembly update and the output copy so the last pixel lands in the window.
  always_comb begin
    filled = asm_q;
    filled[slot*DATA_W +: DATA_W] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      mode_q <= 1'b0;
      asm_q  <= '0;
    end else if (flush) begin
      idx <= '0;
    end else if (accept) begin
      asm_q <= filled;
      if (idx == '0) begin
        mode_q <= col_major;
      end
      idx <= last ? '0 : idx + SLOT_W'(1);
    end
  end

  // Output register FSM; a completing window wins over a plain drain so a
  // same-cycle drain and refill keeps win_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state <= OUT_EMPTY;
      win_data  <= '0;
      win_cnt   <= '0;
    end else begin
      case (out_state)
        OUT_EMPTY: begin
          if (accept && last) begin
            win_data  <= filled;
            win_cnt   <= win_cnt + CNT_W'(1);
            out_state <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (accept && last) begin
            win_data  <= filled;
            win_cnt   <= win_cnt + CNT_W'(1);
          end else if (win_ready) begin
            out_state <= OUT_EMPTY;
          end
        end
        default: out_state <= OUT_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/window_packer.md
WINDOW_PACKER -- requirements
Module: window_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter K, default 3, meaning window side; window holds K*K pixels; legal range 2..7.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the window counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  pixel on in_data is valid.
REQ-007 SHALL have port in_data  input  DATA_W  serial pixel.
REQ-008 SHALL have port in_ready  output  1  pixel accepted when in_valid and in_ready are both 1.
REQ-009 SHALL have port col_major  input  1  arrival order of the window: 0 = row-major, 1 = column-major.
REQ-010 SHALL have port flush  input  1  synchronous discard of a partial window.
REQ-011 SHALL have port win_valid  output  1  win_data holds a complete window.
REQ-012 SHALL have port win_ready  input  1  consumer takes the window when win_valid and win_ready are both 1.
REQ-013 SHALL have port win_data  output  K*K*DATA_W  packed window.
REQ-014 SHALL have port busy  output  1  partial window in progress (idx != 0).
REQ-015 SHALL have port win_cnt  output  CNT_W  count of windows emitted.

Function
REQ-016 SHALL pack slot s = r*K + c (row r, column c) at win_data[s*DATA_W +: DATA_W]; slot 0 (row 0, column 0) is at the LSBs.
REQ-017 SHALL keep a fill index idx, 0..K*K-1, that increments on each accepted pixel and returns to 0 after K*K-1.
REQ-018 SHALL map an accepted pixel to a slot as follows: row-major, slot = idx; column-major, idx = c*K + r is written to slot r*K + c.
REQ-019 SHALL latch col_major when the idx=0 pixel is accepted, and use the latched value for the rest of that window; changes to col_major mid-window are ignored.
REQ-020 SHALL use two states: FILL (assembly register partial) and an output register state (win_valid flag). The output register is independent of the assembly register.
REQ-021 SHALL, when the idx=K*K-1 pixel is accepted, copy the complete assembled window (including that pixel) into the output register, assert win_valid on the next cycle (latency 1), and increment win_cnt (wraps at 2^CNT_W).
REQ-022 SHALL compute in_ready = !flush && !(idx==K*K-1 && win_valid && !win_ready); pixels 0..K*K-2 are never back-pressured.
REQ-023 SHALL allow a same-cycle window drain and refill (win_ready=1 while the last pixel is accepted): win_valid stays 1 and win_data updates to the new window.
REQ-024 SHALL clear win_valid on a drain with no refill; win_data then holds its last value.
REQ-025 SHALL hold win_data stable while win_valid=1 and win_ready=0.
REQ-026 SHALL, on flush=1, set idx to 0 and drop any pixel presented that cycle; flush SHALL NOT affect win_valid, win_data or win_cnt.
REQ-027 SHALL leave stale assembly-register contents unobservable; only complete windows reach win_data.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force idx=0, latched mode=0, win_valid=0, win_data=0, win_cnt=0, busy=0; in_ready SHALL be 1 the first cycle after release.
REQ-029 SHALL discard a partial window or pending output on reset mid-operation; no window is emitted for the discarded data.

Structure
REQ-030 SHALL place the DATA_W and K defaults and the slot-index width constant in the shared package window_pkg.
REQ-031 SHALL implement the combinational idx-to-slot mapping, with the mode input, in sub-module window_slot_map.

Verification
REQ-032 SHALL cover: row-major, pixels 0x01..0x09, win_ready=1 -> one cycle after the 9th pixel, win_valid=1, win_data=0x090807060504030201, win_cnt=1.
REQ-033 SHALL cover: column-major, pixels 0x01..0x09 -> win_data=0x090603080502070401.
REQ-034 SHALL cover: win_ready=0 with window A (0x01..0x09) held; stream window B (0x11..0x19) -> 8 pixels accepted, in_ready=0 at the 9th, win_data remains A; then raise win_ready -> B accepted in the same cycle, win_data=0x191817161514131211 next cycle.
REQ-035 SHALL cover: flush after 4 pixels, then 0x21..0x29 -> win_data=0x292827262524232221, win_cnt increments by exactly 1.
REQ-036 SHALL cover: rst_n pulsed low after 5 pixels with win_valid=1 -> all outputs 0 immediately; the next 9 pixels form a fresh window.
REQ-037 SHALL cover: col_major toggled mid-window -> the window uses the mode sampled at idx=0.
